hc_csr_file: RTL and testbench

- Parametrised HardCloud MMIO control/status register file.
- Decodes CCI-P MMIO writes and reads for the AFU header, the DSM base, the control word and NUM_BUFFERS address/size descriptors.
- Runs the control state machine that resets, starts and stops the datapath.
- Sits between the CCI-P shim (c0 Rx, c2 Tx) and sample datapaths (md5 and later samples); replaces per-sample decode functions.

---
 rtl/hc_pkg.sv | 60 ++++++
 rtl/hc_ctrl_fsm.sv | 61 ++++++
 rtl/hc_csr_file.sv | 119 +++++++++++
 tb/tb_hc_csr_file.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
// hc_pkg: shared constants, CSR types and the minimal CCI-P MMIO channel
// structs used by the HardCloud CSR file and its control FSM.
package hc_pkg;
    localparam logic [15:0] HC_DSM_ADDR  = 16'h110;
    localparam logic [15:0] HC_CTRL_ADDR = 16'h118;
    localparam logic [15:0] HC_STAT_ADDR = 16'h11C;
    localparam logic [15:0] HC_BUF_BASE  = 16'h120;
    // AFU-type DFH, end of list, no next feature.
    localparam logic [63:0] HC_DFH = 64'h1000_0100_0000_0000;

    typedef logic [63:0] t_hc_address;
    typedef logic [31:0] t_hc_control;

    localparam t_hc_control HC_CTRL_ASSERT_RST   = 32'd0;
    localparam t_hc_control HC_CTRL_DEASSERT_RST = 32'd1;
    localparam t_hc_control HC_CTRL_START        = 32'd3;
    localparam t_hc_control HC_CTRL_STOP         = 32'd7;

    typedef struct packed {
        t_hc_address addr;
        logic [31:0] size;
    } t_hc_buffer;

    typedef enum logic [1:0] {S_HOLD, S_READY, S_RUN, S_DONE} t_hc_ctrl_state;

    typedef struct packed {
        logic [27:0]    rsvd;
        t_hc_ctrl_state state;
        logic           done;
        logic           running;
    } t_hc_status;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    function automatic t_hc_address hc_merge64(input t_hc_address cur, input logic [63:0] data,
                                               input logic wide, input logic hi);
        return hi ? {data[31:0], cur[31:0]} : wide ? data : {cur[63:32], data[31:0]};
    endfunction
endpackage

// File: rtl/hc_ctrl_fsm.sv
// hc_ctrl_fsm: datapath control state machine, start pulse and done flag.
module hc_ctrl_fsm
    import hc_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ctrl_wr_i,
    input  t_hc_control    ctrl_i,
    input  logic           dp_done_i,
    output t_hc_ctrl_state state_o,
    output logic           done_flag_o,
    output logic           dp_start_o,
    output logic           dp_reset_o,
    output logic           dp_running_o
);
    t_hc_ctrl_state state_q, state_d;
    logic done_q, done_d, start_q, start_d;
    logic do_rst, do_go;

    assign do_rst = ctrl_wr_i && ctrl_i == HC_CTRL_ASSERT_RST;
    assign do_go  = ctrl_wr_i && ctrl_i == HC_CTRL_START && (state_q == S_READY || state_q == S_DONE);

    // Reset wins outright; a completing datapath wins over a same-cycle STOP so done_flag is kept.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        start_d = do_go;
        if (do_rst) begin
            state_d = S_HOLD;
            done_d  = 1'b0;
        end else if (state_q == S_RUN && dp_done_i) begin
            state_d = S_DONE;
            done_d  = 1'b1;
        end else if (do_go) begin
            state_d = S_RUN;
            done_d  = 1'b0;
        end else if (ctrl_wr_i && ctrl_i == HC_CTRL_DEASSERT_RST && state_q == S_HOLD) begin
            state_d = S_READY;
        end else if (ctrl_wr_i && ctrl_i == HC_CTRL_STOP && state_q == S_RUN) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_HOLD;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            start_q <= start_d;
        end
    end

    assign state_o      = state_q;
    assign done_flag_o  = done_q;
    assign dp_start_o   = start_q;
    assign dp_reset_o   = state_q == S_HOLD;
    assign dp_running_o = state_q == S_RUN;
endmodule

// File: rtl/hc_csr_file.sv
// hc_csr_file: HardCloud MMIO CSR file -- AFU header, DSM base, control/status
// and buffer descriptors, with registered one-cycle read responses.
module hc_csr_file
    import hc_pkg::*;
#(
    parameter int           NUM_BUFFERS = 4,
    parameter logic [127:0] AFU_ID      = 128'h0,
    parameter logic [15:0]  BUF_BASE    = HC_BUF_BASE,
    parameter logic [15:0]  DSM_ADDR    = HC_DSM_ADDR,
    parameter logic [15:0]  CTRL_ADDR   = HC_CTRL_ADDR,
    parameter logic [15:0]  STAT_ADDR   = HC_STAT_ADDR
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  t_if_ccip_c0_Rx           rx_c0,
    output t_if_ccip_c2_Tx           tx_c2,
    output logic [63:0]              dsm_base,
    output logic [NUM_BUFFERS*64-1:0] buf_addr,
    output logic [NUM_BUFFERS*32-1:0] buf_size,
    output logic                     dp_reset,
    output logic                     dp_start,
    output logic                     dp_running,
    input  logic                     dp_done
);
    localparam logic [15:0] W_DSM  = DSM_ADDR >> 2;
    localparam logic [15:0] W_CTRL = CTRL_ADDR >> 2;
    localparam logic [15:0] W_STAT = STAT_ADDR >> 2;
    localparam logic [15:0] W_BUF  = BUF_BASE >> 2;
    localparam logic [15:0] W_SPAN = 16'(4 * NUM_BUFFERS);

    t_hc_buffer     bufs_q [NUM_BUFFERS];
    t_hc_buffer     bufs_d [NUM_BUFFERS];
    t_hc_address    dsm_q, dsm_d;
    t_hc_control    ctrl_q, ctrl_d;
    t_if_ccip_c2_Tx tx_q, tx_d;
    t_hc_ctrl_state state;
    t_hc_status     status;
    logic           done_flag;
    logic [15:0]    addr, boff;
    logic           wide, in_buf, wr_ok, ctrl_wr;

    assign addr    = rx_c0.hdr.address;
    assign wide    = rx_c0.hdr.length == 2'd1;
    assign boff    = addr - W_BUF;
    assign in_buf  = addr >= W_BUF && boff < W_SPAN;
    assign wr_ok   = rx_c0.mmioWrValid && state != S_RUN;
    assign ctrl_wr = rx_c0.mmioWrValid && addr == W_CTRL;
    assign status  = '{rsvd: '0, state: state, done: done_flag, running: dp_running};

    // Each descriptor spans four words: address lo, address hi, size, unused.
    always_comb begin
        dsm_d  = dsm_q;
        ctrl_d = ctrl_q;
        bufs_d = bufs_q;
        if (wr_ok && (addr == W_DSM || addr == W_DSM + 16'd1))
            dsm_d = hc_merge64(dsm_q, rx_c0.data, wide, addr != W_DSM);
        for (int i = 0; i < NUM_BUFFERS; i++)
            if (wr_ok && in_buf && boff[5:2] == 4'(i)) begin
                if (!boff[1]) bufs_d[i].addr = hc_merge64(bufs_q[i].addr, rx_c0.data, wide, boff[0]);
                if (boff[1:0] == 2'd2) bufs_d[i].size = rx_c0.data[31:0];
            end
        if (ctrl_wr) ctrl_d = rx_c0.data[31:0];
    end

    always_comb begin
        tx_d             = '0;
        tx_d.mmioRdValid = rx_c0.mmioRdValid;
        tx_d.hdr.tid     = rx_c0.hdr.tid;
        tx_d.data = addr == 16'd0          ? HC_DFH
                  : addr == 16'd2          ? AFU_ID[63:0]
                  : addr == 16'd4          ? AFU_ID[127:64]
                  : addr == W_DSM          ? dsm_q
                  : addr == W_DSM + 16'd1  ? {32'h0, dsm_q[63:32]}
                  : addr == W_CTRL         ? {32'h0, ctrl_q}
                  : addr == W_STAT         ? {32'h0, status}
                  : 64'h0;
        for (int i = 0; i < NUM_BUFFERS; i++)
            if (in_buf && boff[5:2] == 4'(i))
                tx_d.data = boff[1:0] == 2'd0 ? bufs_q[i].addr
                          : boff[1:0] == 2'd1 ? {32'h0, bufs_q[i].addr[63:32]}
                          : boff[1:0] == 2'd2 ? {32'h0, bufs_q[i].size}
                          : 64'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dsm_q  <= '0;
            ctrl_q <= '0;
            tx_q   <= '0;
            bufs_q <= '{default: '0};
        end else begin
            dsm_q  <= dsm_d;
            ctrl_q <= ctrl_d;
            tx_q   <= tx_d;
            bufs_q <= bufs_d;
        end
    end

    hc_ctrl_fsm u_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .ctrl_wr_i    (ctrl_wr),
        .ctrl_i       (rx_c0.data[31:0]),
        .dp_done_i    (dp_done),
        .state_o      (state),
        .done_flag_o  (done_flag),
        .dp_start_o   (dp_start),
        .dp_reset_o   (dp_reset),
        .dp_running_o (dp_running)
    );

    for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_buf
        assign buf_addr[g*64 +: 64] = bufs_q[g].addr;
        assign buf_size[g*32 +: 32] = bufs_q[g].size;
    end

    assign tx_c2    = tx_q;
    assign dsm_base = dsm_q;
endmodule

// File: tb/tb_hc_csr_file.sv
// tb_hc_csr_file: directed MMIO traffic against a word-addressed register model,
// checked every cycle, plus literal expectations on key reads and pulses.
module tb_hc_csr_file;
    import hc_pkg::*;

    localparam int           NB     = 2;
    localparam logic [127:0] AFU    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam int           W_DSM  = 'h110 / 4;
    localparam int           W_CTRL = 'h118 / 4;
    localparam int           W_STAT = 'h11C / 4;
    localparam int           W_BUF  = 'h120 / 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic dp_done = 1'b0;
    t_if_ccip_c0_Rx rx = '0;
    t_if_ccip_c2_Tx tx;
    logic [63:0]      dsm_base;
    logic [NB*64-1:0] buf_addr;
    logic [NB*32-1:0] buf_size;
    logic dp_reset, dp_start, dp_running;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hc_csr_file #(.NUM_BUFFERS(NB), .AFU_ID(AFU)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_c0      (rx),
        .tx_c2      (tx),
        .dsm_base   (dsm_base),
        .buf_addr   (buf_addr),
        .buf_size   (buf_size),
        .dp_reset   (dp_reset),
        .dp_start   (dp_start),
        .dp_running (dp_running),
        .dp_done    (dp_done)
    );

    // Model: the register file is a plain array of 32-bit words; states 0..3 = HOLD, READY, RUN, DONE.
    logic [31:0] mem [0:255];
    int          m_state;
    logic        m_done, m_start, m_rv;
    logic [8:0]  m_tid;
    logic [63:0] m_rdata;
    int          a_w;

    assign a_w = int'(rx.hdr.address);

    function automatic bit is_desc(int w);
        return w >= W_BUF && w < W_BUF + 4 * NB;
    endfunction
    function automatic bit is_lo64(int w);
        return w == W_DSM || (is_desc(w) && (w - W_BUF) % 4 == 0);
    endfunction
    function automatic bit is_hi(int w);
        return w == W_DSM + 1 || (is_desc(w) && (w - W_BUF) % 4 == 1);
    endfunction
    function automatic bit is_reg(int w);
        return w == W_DSM || w == W_DSM + 1 || w == W_CTRL || (is_desc(w) && (w - W_BUF) % 4 != 3);
    endfunction
    function automatic logic [63:0] m_read(int w);
        if (w == 0) return 64'h1000_0100_0000_0000;
        if (w == 2) return AFU[63:0];
        if (w == 4) return AFU[127:64];
        if (w == W_STAT) return {60'h0, 2'(m_state), m_done, m_state == 2};
        if (is_lo64(w)) return {mem[w+1], mem[w]};
        if (is_reg(w)) return {32'h0, mem[w]};
        return 64'h0;
    endfunction
    function automatic int ctrl_target(int s, logic [31:0] cmd);
        case (cmd)
            32'd0:   return 0;
            32'd1:   return s == 0 ? 1 : s;
            32'd3:   return (s == 1 || s == 3) ? 2 : s;
            32'd7:   return s == 2 ? 3 : s;
            default: return s;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            m_state <= 0;
            m_done  <= 1'b0;
            m_start <= 1'b0;
            m_rv    <= 1'b0;
            m_tid   <= '0;
            m_rdata <= '0;
        end else begin
            m_rv    <= rx.mmioRdValid;
            m_tid   <= rx.hdr.tid;
            m_rdata <= m_read(a_w);
            m_start <= 1'b0;
            if (rx.mmioWrValid && a_w == W_CTRL && rx.data[31:0] == 32'd0) begin
                m_state <= 0;
                m_done  <= 1'b0;
            end else if (m_state == 2 && dp_done) begin
                m_state <= 3;
                m_done  <= 1'b1;
            end else if (rx.mmioWrValid && a_w == W_CTRL) begin
                m_state <= ctrl_target(m_state, rx.data[31:0]);
                if (m_state != 2 && ctrl_target(m_state, rx.data[31:0]) == 2) begin
                    m_start <= 1'b1;
                    m_done  <= 1'b0;
                end
            end
            if (rx.mmioWrValid && is_reg(a_w) && (a_w == W_CTRL || m_state != 2)) begin
                mem[a_w] <= rx.data[31:0];
                if (rx.hdr.length == 2'd1 && is_hi(a_w + 1)) mem[a_w+1] <= rx.data[63:32];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("dp_reset", 64'(dp_reset), 64'(m_state == 0));
        chk("dp_running", 64'(dp_running), 64'(m_state == 2));
        chk("dp_start", 64'(dp_start), 64'(m_start));
        chk("dsm_base", dsm_base, {mem[W_DSM+1], mem[W_DSM]});
        for (int i = 0; i < NB; i++) begin
            chk("buf_addr", buf_addr[i*64 +: 64], {mem[W_BUF+4*i+1], mem[W_BUF+4*i]});
            chk("buf_size", 64'(buf_size[i*32 +: 32]), 64'(mem[W_BUF+4*i+2]));
        end
        chk("rsp_valid", 64'(tx.mmioRdValid), 64'(m_rv));
        if (m_rv) begin
            chk("rsp_tid", 64'(tx.hdr.tid), 64'(m_tid));
            chk("rsp_data", tx.data, m_rdata);
        end
    end

    task automatic drive(input logic w, input logic [15:0] a, input logic [63:0] d,
                         input logic wide, input logic done);
        @(posedge clk); #1;
        rx = '0;
        rx.mmioWrValid = w;
        rx.hdr.address = a >> 2;
        rx.hdr.length  = wide ? 2'd1 : 2'd0;
        rx.data        = d;
        dp_done        = done;
        @(posedge clk); #1;
        rx      = '0;
        dp_done = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d, input logic wide);
        drive(1'b1, a, d, wide, 1'b0);
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [8:0] tid, input logic [63:0] exp);
        @(posedge clk); #1;
        rx = '0;
        rx.mmioRdValid = 1'b1;
        rx.hdr.address = a >> 2;
        rx.hdr.tid     = tid;
        @(posedge clk); #1;
        rx = '0;
        chk({name, "_valid"}, 64'(tx.mmioRdValid), 64'd1);
        chk({name, "_tid"}, 64'(tx.hdr.tid), 64'(tid));
        chk(name, tx.data, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_dp_reset", 64'(dp_reset), 64'd1);
        chk("rst_dp_start", 64'(dp_start), 64'd0);
        chk("rst_tx_valid", 64'(tx.mmioRdValid), 64'd0);
        rd("rst_status", 16'h11C, 9'h001, 64'h0);
        rd("dfh", 16'h000, 9'h002, 64'h1000_0100_0000_0000);
        rd("afu_lo", 16'h008, 9'h003, 64'hFEDC_BA98_7654_3210);
        rd("afu_hi", 16'h010, 9'h004, 64'h0123_4567_89AB_CDEF);
        rd("rsvd_018", 16'h018, 9'h005, 64'h0);

        wr(16'h118, 64'd3, 1'b0);
        chk("start_in_hold_pulse", 64'(dp_start), 64'd0);
        chk("start_in_hold_reset", 64'(dp_reset), 64'd1);
        wr(16'h118, 64'd1, 1'b0);
        chk("deassert_dp_reset", 64'(dp_reset), 64'd0);
        rd("status_ready", 16'h11C, 9'h006, 64'h4);
        wr(16'h118, 64'd5, 1'b0);
        rd("status_after_5", 16'h11C, 9'h007, 64'h4);
        rd("ctrl_readback", 16'h118, 9'h008, 64'h5);

        wr(16'h130, 64'hDEAD_BEEF_0000_1000, 1'b1);
        wr(16'h138, 64'h0000_0000_0000_4000, 1'b0);
        rd("buf1_addr", 16'h130, 9'h011, 64'hDEAD_BEEF_0000_1000);
        rd("buf1_size", 16'h138, 9'h012, 64'h4000);
        chk("buf1_addr_port", buf_addr[127:64], 64'hDEAD_BEEF_0000_1000);
        chk("buf1_size_port", 64'(buf_size[63:32]), 64'h4000);
        wr(16'h140, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        rd("unmapped_140", 16'h140, 9'h013, 64'h0);
        wr(16'h110, 64'h1111_2222_3333_4444, 1'b1);
        wr(16'h114, 64'h0000_0000_5555_6666, 1'b0);
        rd("dsm_full", 16'h110, 9'h014, 64'h5555_6666_3333_4444);
        rd("dsm_hi", 16'h114, 9'h015, 64'h5555_6666);

        wr(16'h118, 64'd3, 1'b0);
        chk("start_pulse_on", 64'(dp_start), 64'd1);
        @(posedge clk); #1;
        chk("start_pulse_off", 64'(dp_start), 64'd0);
        chk("running", 64'(dp_running), 64'd1);
        rd("status_run", 16'h11C, 9'h020, 64'h9);

        wr(16'h120, 64'h1234, 1'b0);
        chk("buf0_locked_in_run", buf_addr[63:0], 64'h0);
        wr(16'h118, 64'd7, 1'b0);
        rd("status_stopped", 16'h11C, 9'h021, 64'hC);
        wr(16'h120, 64'h1234, 1'b0);
        chk("buf0_after_stop", buf_addr[63:0], 64'h1234);

        wr(16'h118, 64'd3, 1'b0);
        drive(1'b1, 16'h118, 64'd7, 1'b0, 1'b1);
        rd("status_stop_and_done", 16'h11C, 9'h022, 64'hE);
        wr(16'h118, 64'd3, 1'b0);
        chk("restart_pulse", 64'(dp_start), 64'd1);
        rd("status_restart", 16'h11C, 9'h023, 64'h9);
        drive(1'b0, 16'h000, 64'h0, 1'b0, 1'b1);
        rd("status_hw_done", 16'h11C, 9'h024, 64'hE);
        wr(16'h118, 64'd3, 1'b0);
        drive(1'b1, 16'h118, 64'd0, 1'b0, 1'b1);
        chk("assert_rst_priority", 64'(dp_reset), 64'd1);
        rd("status_assert_rst", 16'h11C, 9'h025, 64'h0);

        wr(16'h118, 64'd1, 1'b0);
        wr(16'h118, 64'd3, 1'b0);
        @(posedge clk); #1;
        rx = '0;
        rx.mmioRdValid = 1'b1;
        rx.hdr.address = 16'h11C >> 2;
        rx.hdr.tid     = 9'h1AB;
        #2 reset_n = 1'b0;
        @(posedge clk); #1;
        rx = '0;
        chk("rst_drop_rsp", 64'(tx.mmioRdValid), 64'd0);
        chk("rst_mid_dp_reset", 64'(dp_reset), 64'd1);
        chk("rst_mid_running", 64'(dp_running), 64'd0);
        chk("rst_mid_dsm", dsm_base, 64'h0);
        chk("rst_mid_buf1", buf_addr[127:64], 64'h0);
        #1 reset_n = 1'b1;
        rd("post_rst_buf1", 16'h130, 9'h030, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
